seq_mul_unit: RTL and testbench

Parametrised sequential shift-add multiplier. It is the successor to the combinational, button-stepped multiplier used in the board demo.
- Operands are captured on a start handshake, and one partial-product iteration runs per enabled clock.
- Supports unsigned and two's-complement signed modes.
- Exposes the iteration count, busy and done so the display path can show progress while single-stepping from a debounced button.

---
 rtl/seq_mul_unit_pkg.sv | 14 +
 rtl/seq_mul_unit_if.sv | 25 ++
 rtl/seq_mul_unit.sv | 76 +++++++
 tb/tb_seq_mul_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_unit_pkg.sv
// seq_mul_unit_pkg: shared constants and types for the sequential multiplier.
//   DEF_WIDTH : default operand width
//   ST_*      : 2-bit state encodings; state_t enumerates them
package seq_mul_unit_pkg;
    localparam int DEF_WIDTH = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/seq_mul_unit_if.sv
// seq_mul_unit_if: request/result bundle of the sequential multiplier.
//   master drives start, step, signed_mode, multiplier, multiplicand
//   master observes result, busy, done, iter; slave is the mirror view
interface seq_mul_unit_if import seq_mul_unit_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic                 start;
    logic                 step;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplicand;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     iter;
    modport master (
        output start, step, signed_mode, multiplier, multiplicand,
        input  result, busy, done, iter
    );
    modport slave (
        input  start, step, signed_mode, multiplier, multiplicand,
        output result, busy, done, iter
    );
endinterface

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: shift-add multiplier, one partial product per enabled clock.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : start/step/signed_mode/operands in; result/busy/done/iter out
module seq_mul_unit import seq_mul_unit_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic           clock,
    input logic           reset,
    seq_mul_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg;
    logic [2*WIDTH-1:0] acc, acc_nx, result_q;
    logic [WIDTH:0]     sum;
    logic [CNT_W-1:0]   iter_q;
    logic               accept, adv, last;

    // Signed operands are reduced to magnitudes; the most negative value maps
    // to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept = (state_q != RUN) && bus.start;
    assign adv    = (state_q == RUN) && bus.step;
    assign last   = adv && (iter_q == CNT_W'(WIDTH - 1));

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_a[0] ? {1'b0, mag_b} : '0);
        // Carry of the upper-half add shifts in as the new MSB.
        acc_nx  = {sum, acc[WIDTH-1:1]};
        state_d = state_q;
        if (accept)
            state_d = RUN;
        else if (last)
            state_d = DONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag_a    <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            iter_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            mag_a  <= mag(bus.multiplier, bus.signed_mode);
            mag_b  <= mag(bus.multiplicand, bus.signed_mode);
            neg    <= bus.signed_mode & (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);
            acc    <= '0;
            iter_q <= '0;
        end else if (adv) begin
            acc    <= acc_nx;
            mag_a  <= mag_a >> 1;
            iter_q <= iter_q + 1'b1;
            if (last)
                result_q <= neg ? -acc_nx : acc_nx;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.iter   = iter_q;
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed self-checking bench for seq_mul_unit (WIDTH=4).
module tb_seq_mul_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_mul_unit_if #(.WIDTH(4)) bus ();
    seq_mul_unit #(.WIDTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic sm, input logic stp);
        bus.multiplier   = a;
        bus.multiplicand = b;
        bus.signed_mode  = sm;
        bus.step         = stp;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.iter, bus.result} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b iter=%0d result=%h exp all 0", bus.busy, bus.done, bus.iter, bus.result);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        launch(4'd13, 4'd11, 1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.iter !== 3'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_edge got busy=%b iter=%0d done=%b exp busy=1 iter=0 done=0", bus.busy, bus.iter, bus.done);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.iter !== 3'(i) || bus.busy !== (i < 4) || bus.done !== (i == 4)) begin
                errors++;
                $display("FAIL unsigned_progress got iter=%0d busy=%b done=%b exp iter=%0d busy=%b done=%b", bus.iter, bus.busy, bus.done, i, i < 4, i == 4);
            end
        end
        checks++;
        if (bus.result !== 8'h8F) begin
            errors++;
            $display("FAIL unsigned_13x11 got %h exp 8f", bus.result);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h8F || bus.iter !== 3'd4) begin
            errors++;
            $display("FAIL done_hold got done=%b result=%h iter=%0d exp 1 8f 4", bus.done, bus.result, bus.iter);
        end
    endtask

    task automatic test_signed();
        logic [3:0] ta [4] = '{4'hD, 4'h8, 4'hF, 4'h3};
        logic [3:0] tb [4] = '{4'h5, 4'h8, 4'hF, 4'hE};
        logic       ts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] te [4] = '{8'hF1, 8'h40, 8'hE1, 8'hFA};
        int n;
        for (int k = 0; k < 4; k++) begin
            launch(ta[k], tb[k], ts[k], 1'b1);
            n = 0;
            while (!bus.done && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 4) begin
                errors++;
                $display("FAIL mode_latency case %0d got %0d cycles exp 4", k, n);
            end
            checks++;
            if (bus.result !== te[k]) begin
                errors++;
                $display("FAIL mode_result case %0d got %h exp %h", k, bus.result, te[k]);
            end
        end
    endtask

    task automatic test_single_step();
        launch(4'd7, 4'd6, 1'b0, 1'b0);
        for (int p = 1; p <= 4; p++) begin
            for (int q = 0; q < 4; q++) begin
                tick();
                checks++;
                if (bus.iter !== 3'(p - 1) || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL step_hold got iter=%0d busy=%b exp iter=%0d busy=1", bus.iter, bus.busy, p - 1);
                end
            end
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            checks++;
            if (bus.iter !== 3'(p) || bus.done !== (p == 4)) begin
                errors++;
                $display("FAIL step_pulse got iter=%0d done=%b exp iter=%0d done=%b", bus.iter, bus.done, p, p == 4);
            end
        end
        checks++;
        if (bus.result !== 8'h2A) begin
            errors++;
            $display("FAIL step_7x6 got %h exp 2a", bus.result);
        end
    endtask

    task automatic test_back_to_back();
        launch(4'd9, 4'd9, 1'b0, 1'b1);
        tick();
        tick();
        bus.multiplier   = 4'd3;
        bus.multiplicand = 4'd3;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        checks++;
        if (bus.iter !== 3'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL run_start_ignored got iter=%0d busy=%b exp iter=3 busy=1", bus.iter, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h51) begin
            errors++;
            $display("FAIL run_9x9 got done=%b result=%h exp 1 51", bus.done, bus.result);
        end
        launch(4'd2, 4'd3, 1'b0, 1'b1);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.iter !== 3'd0 || bus.result !== 8'h51) begin
            errors++;
            $display("FAIL done_restart got done=%b busy=%b iter=%0d result=%h exp 0 1 0 51", bus.done, bus.busy, bus.iter, bus.result);
        end
        repeat (4) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h06) begin
            errors++;
            $display("FAIL restart_2x3 got done=%b result=%h exp 1 06", bus.done, bus.result);
        end
    endtask

    task automatic test_async_reset();
        launch(4'd5, 4'd5, 1'b0, 1'b1);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.iter, bus.result} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b iter=%0d result=%h exp all 0", bus.busy, bus.done, bus.iter, bus.result);
        end
        tick();
        reset = 1'b0;
        tick();
        launch(4'd0, 4'd12, 1'b1, 1'b1);
        repeat (3) tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_early got done=%b busy=%b exp 0 1", bus.done, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h00) begin
            errors++;
            $display("FAIL zero_0x12 got done=%b result=%h exp 1 00", bus.done, bus.result);
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.step         = 1'b0;
        bus.signed_mode  = 1'b0;
        bus.multiplier   = '0;
        bus.multiplicand = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_single_step();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
